// File: rtl/pkg_dtypes.sv
// rtl/pkg_dtypes.sv - shared execution-unit operand types
package pkg_dtypes;

   typedef logic [7:0]  type_exec_unit_addr;
   typedef logic [15:0] type_exec_unit_data;

endpackage

// File: rtl/eu_xbuf_tx_if.sv
// rtl/eu_xbuf_tx_if.sv - enqueue/xbuf-facing signal bundle of the xbuf transmit queue
interface eu_xbuf_tx_if #(
   parameter int NUM_IDX_BITS = 2
);
   import pkg_dtypes::*;

   type_exec_unit_addr      enq_addr_i;
   type_exec_unit_data      enq_data_i;
   logic                    enq_valid_i;
   logic                    enq_ready_o;
   type_exec_unit_addr      tx_addr_o;
   type_exec_unit_data      tx_data_o;
   logic                    tx_valid_o;
   logic                    tx_success_i;
   logic [NUM_IDX_BITS:0]   count_o;
   logic                    stall_o;

   modport slave (
      input  enq_addr_i, enq_data_i, enq_valid_i, tx_success_i,
      output enq_ready_o, tx_addr_o, tx_data_o, tx_valid_o, count_o, stall_o
   );

   modport master (
      output enq_addr_i, enq_data_i, enq_valid_i, tx_success_i,
      input  enq_ready_o, tx_addr_o, tx_data_o, tx_valid_o, count_o, stall_o
   );

endinterface

// File: rtl/eu_xbuf_tx.sv
// rtl/eu_xbuf_tx.sv - FIFO feeding the xbuf input port, with head-refusal stall monitor
module eu_xbuf_tx
   import pkg_dtypes::*;
#(
   parameter int NUM_IDX_BITS   = 2,
   parameter int STALL_CNT_BITS = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   eu_xbuf_tx_if.slave   xb
);

   localparam int                     DEPTH = 2**NUM_IDX_BITS;
   localparam logic [NUM_IDX_BITS:0]  FULL  = (NUM_IDX_BITS+1)'(DEPTH);
   localparam logic [STALL_CNT_BITS-1:0] SAT = '1;

   type_exec_unit_addr              addr_q [DEPTH];
   type_exec_unit_addr              addr_d [DEPTH];
   type_exec_unit_data              data_q [DEPTH];
   type_exec_unit_data              data_d [DEPTH];
   logic [NUM_IDX_BITS-1:0]         wr_ptr_q, wr_ptr_d;
   logic [NUM_IDX_BITS-1:0]         rd_ptr_q, rd_ptr_d;
   logic [NUM_IDX_BITS:0]           count_q, count_d;
   logic [STALL_CNT_BITS-1:0]       stall_cnt_q, stall_cnt_d;

   logic enq_ready;
   logic tx_valid;
   logic push;
   logic pop;

   // Handshakes depend only on registered occupancy: no bypass when full.
   always_comb begin
      enq_ready = (count_q != FULL);
      tx_valid  = (count_q != '0);
      push      = xb.enq_valid_i & enq_ready;
      pop       = tx_valid & xb.tx_success_i;
   end

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         addr_d[wr_ptr_q] = xb.enq_addr_i;
         data_d[wr_ptr_q] = xb.enq_data_i;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Counts consecutive refusals of the current head; a pop starts a new head.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!tx_valid || pop) begin
         stall_cnt_d = '0;
      end else if (stall_cnt_q != SAT) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign xb.enq_ready_o = enq_ready;
   assign xb.tx_valid_o  = tx_valid;
   assign xb.tx_addr_o   = addr_q[rd_ptr_q];
   assign xb.tx_data_o   = data_q[rd_ptr_q];
   assign xb.count_o     = count_q;
   assign xb.stall_o     = (stall_cnt_q == SAT);

endmodule
